// File: rtl/spi_rx_sequencer.sv
// Master-side SPI mode-0 receiver: frames SIZE bits LSB-first from the driver
// and hands the word to the motion logic over a valid/ready port with overrun flag.

module spi_rx_sipo #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            data_in,
    output logic [SIZE-1:0] data
);
    // Right shift with insertion at the MSB: the first bit received ends in bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (en) begin
            data <= {data_in, data[SIZE-1:1]};
        end
    end
endmodule

module spi_rx_sequencer #(
    parameter int SIZE    = 8,
    parameter int CLK_DIV = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            start_in,
    input  logic            miso_in,
    input  logic            ready_in,
    output logic            sclk_out,
    output logic            cs_n_out,
    output logic [SIZE-1:0] r_data_out,
    output logic            valid_out,
    output logic            busy_out,
    output logic            overrun_out
);
    localparam int BIT_W = $clog2(SIZE + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] LOW   = 3'd2;
    localparam logic [2:0] HIGH  = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [BIT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             div_last;
    logic             shift_en;
    logic             done;
    logic [SIZE-1:0]  sipo_data;

    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_nx = state;
        shift_en = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:  if (start_in) state_nx = SETUP;
            SETUP: if (div_last) state_nx = LOW;
            LOW:   if (div_last) state_nx = HIGH;
            HIGH: begin
                if (div_last) begin
                    shift_en = 1'b1;
                    state_nx = (bit_cnt == BIT_W'(SIZE - 1)) ? HOLD : LOW;
                end
            end
            HOLD: begin
                if (div_last) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Every non-idle state ends on its last divider cycle, so the divider
    // restarts exactly when the state changes.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state != IDLE && !div_last) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end else begin
                div_cnt <= '0;
            end
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

    spi_rx_sipo #(.SIZE(SIZE)) u_sipo (
        .clk     (clk_in),
        .rst     (rst_in),
        .en      (shift_en),
        .data_in (miso_in),
        .data    (sipo_data)
    );

    // Pin and status outputs are registered from the next state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sclk_out <= 1'b0;
            cs_n_out <= 1'b1;
            busy_out <= 1'b0;
        end else begin
            sclk_out <= (state_nx == HIGH);
            cs_n_out <= (state_nx == IDLE);
            busy_out <= (state_nx != IDLE);
        end
    end

    // Output handshake: valid_out && ready_in consumes; a completion always wins.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_data_out  <= '0;
            valid_out   <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            if (done) begin
                r_data_out <= sipo_data;
                valid_out  <= 1'b1;
                if (valid_out && !ready_in) begin
                    overrun_out <= 1'b1;
                end
            end else begin
                if (valid_out && ready_in) begin
                    valid_out <= 1'b0;
                end
                if (state == IDLE && start_in) begin
                    overrun_out <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_rx_sequencer.sv
// Bench for spi_rx_sequencer: transaction-timeline reference model, per-cycle
// compare process, directed scenarios and a randomized start/ready/miso run.

module tb_spi_rx_sequencer;
    localparam int SIZE    = 8;
    localparam int CLK_DIV = 2;
    localparam int L       = CLK_DIV * (2 * SIZE + 2);

    logic            clk;
    logic            rst;
    logic            start;
    logic            miso;
    logic            ready;
    logic            sclk_out;
    logic            cs_n_out;
    logic [SIZE-1:0] r_data_out;
    logic            valid_out;
    logic            busy_out;
    logic            overrun_out;

    spi_rx_sequencer #(.SIZE(SIZE), .CLK_DIV(CLK_DIV)) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .start_in    (start),
        .miso_in     (miso),
        .ready_in    (ready),
        .sclk_out    (sclk_out),
        .cs_n_out    (cs_n_out),
        .r_data_out  (r_data_out),
        .valid_out   (valid_out),
        .busy_out    (busy_out),
        .overrun_out (overrun_out)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
        end else begin
            passed++;
        end
    endtask

    // Reference model: a transaction accepted at cycle t0 occupies cycles
    // t0+1 .. t0+L; bit j is sampled on cycle t0 + CLK_DIV*(2j+3).
    int              n;
    int              t0;
    logic [SIZE-1:0] acc;
    logic [SIZE-1:0] m_data;
    logic            m_valid;
    logic            m_ovr;
    logic [SIZE-1:0] cur_word;
    logic            exp_sclk, exp_cs_n, exp_busy;
    logic            chk_en;

    function automatic logic active_at(input int c);
        int k;
        k = c - t0;
        return (k >= 1 && k <= L);
    endfunction

    function automatic int sample_bit(input int c);
        int k;
        int p;
        k = c - t0;
        if (k >= 1 && k <= L && (k % CLK_DIV) == 0) begin
            p = k / CLK_DIV;
            if ((p % 2) == 1 && p >= 3 && p <= 2 * SIZE + 1) return (p - 3) / 2;
        end
        return -1;
    endfunction

    task automatic compute_exp();
        int k;
        int phase;
        k = n - t0;
        exp_busy = active_at(n);
        exp_cs_n = !active_at(n);
        exp_sclk = 1'b0;
        if (active_at(n)) begin
            phase = (k - 1) / CLK_DIV;
            exp_sclk = (phase >= 2 && phase <= 2 * SIZE && (phase % 2) == 0);
        end
    endtask

    task automatic model_reset();
        t0      = -1000000;
        acc     = '0;
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        compute_exp();
    endtask

    task automatic model_update(input logic s, input logic r, input logic m);
        int j;
        if (active_at(n)) begin
            j = sample_bit(n);
            if (j >= 0) acc[j] = m;
            if (n - t0 == L) begin
                if (m_valid && !r) m_ovr = 1'b1;
                m_data  = acc;
                m_valid = 1'b1;
            end else if (m_valid && r) begin
                m_valid = 1'b0;
            end
        end else begin
            if (s) begin
                t0    = n;
                m_ovr = 1'b0;
            end
            if (m_valid && r) m_valid = 1'b0;
        end
    endtask

    // Driver tasks: inputs for cycle n are set just after the preceding edge.
    task automatic tick();
        @(posedge clk);
        model_update(start, ready, miso);
        n++;
        compute_exp();
        #1;
    endtask

    task automatic cyc(input logic s, input logic r);
        int j;
        start = s;
        ready = r;
        j = sample_bit(n);
        miso = (j >= 0) ? cur_word[j] : 1'($urandom_range(0, 1));
        tick();
    endtask

    // Compare process
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("sclk", 32'(sclk_out), 32'(exp_sclk));
            check("cs_n", 32'(cs_n_out), 32'(exp_cs_n));
            check("busy", 32'(busy_out), 32'(exp_busy));
            check("valid", 32'(valid_out), 32'(m_valid));
            check("overrun", 32'(overrun_out), 32'(m_ovr));
            check("r_data", 32'(r_data_out), 32'(m_data));
        end
    end

    // Edge and occupancy counters for the directed read
    int   rise_cnt;
    int   busy_cnt;
    int   valid_rise_n;
    logic sclk_prev = 1'b0;
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        if (sclk_out && !sclk_prev && !cs_n_out) rise_cnt++;
        if (busy_out) busy_cnt++;
        if (valid_out && !valid_prev) valid_rise_n = n;
        sclk_prev  <= sclk_out;
        valid_prev <= valid_out;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"}, 32'(cs_n_out), 32'd1);
        check({tag, "_sclk"}, 32'(sclk_out), 32'd0);
        check({tag, "_valid"}, 32'(valid_out), 32'd0);
        check({tag, "_busy"}, 32'(busy_out), 32'd0);
        check({tag, "_overrun"}, 32'(overrun_out), 32'd0);
        check({tag, "_data"}, 32'(r_data_out), 32'd0);
    endtask

    initial begin
        int s0;
        int s1;
        int s2;
        logic s;
        rst = 1'b0; start = 1'b0; ready = 1'b0; miso = 1'b0;
        chk_en = 1'b0; cur_word = '0; n = 0;
        rise_cnt = 0; busy_cnt = 0; valid_rise_n = -1;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        compute_exp();
        chk_en = 1'b1;

        // Basic read with ignored starts at cycles 5 and 20
        cur_word = 8'h4D;
        rise_cnt = 0; busy_cnt = 0; valid_rise_n = -1;
        s0 = n;
        cyc(1'b1, 1'b0);
        for (int i = 1; i <= 44; i++) cyc(i == 5 || i == 20, 1'b0);
        check("basic_word", 32'(r_data_out), 32'h4D);
        check("basic_valid_cycle", 32'(valid_rise_n - s0), 32'd37);
        check("basic_sclk_rises", 32'(rise_cnt), 32'd8);
        check("basic_busy_cycles", 32'(busy_cnt), 32'd36);

        // Overrun: unconsumed 0x4D overwritten by all ones
        cur_word = 8'hFF;
        cyc(1'b1, 1'b0);
        repeat (L + 4) cyc(1'b0, 1'b0);
        check("ovr_word", 32'(r_data_out), 32'hFF);
        check("ovr_flag", 32'(overrun_out), 32'd1);

        // Next start clears overrun; consume exactly in the completion cycle
        cur_word = 8'h3C;
        s1 = n;
        cyc(1'b1, 1'b0);
        check("ovr_clear", 32'(overrun_out), 32'd0);
        while (n <= s1 + L) cyc(1'b0, n == s1 + L);
        check("simul_word", 32'(r_data_out), 32'h3C);
        check("simul_valid", 32'(valid_out), 32'd1);
        check("simul_overrun", 32'(overrun_out), 32'd0);
        cyc(1'b0, 1'b1);
        check("consume_valid", 32'(valid_out), 32'd0);

        // Reset at cycle 15 of a transaction, then a clean 0xA5 read
        cur_word = 8'($urandom);
        s2 = n;
        cyc(1'b1, 1'b0);
        while (n < s2 + 15) cyc(1'b0, 1'b0);
        #3 rst = 1'b1;
        #1 check_reset_outputs("midreset");
        start = 1'b0;
        ready = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        cur_word = 8'hA5;
        cyc(1'b1, 1'b0);
        repeat (L + 2) cyc(1'b0, 1'b0);
        check("after_reset_word", 32'(r_data_out), 32'hA5);
        check("after_reset_valid", 32'(valid_out), 32'd1);

        // Randomized starts, consumer readiness and miso
        repeat (1500) begin
            s = ($urandom_range(0, 7) == 0);
            if (s && !active_at(n)) cur_word = 8'($urandom);
            cyc(s, 1'($urandom_range(0, 1)));
        end
        repeat (L + 2) cyc(1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
